serial_addsub: RTL and testbench

Bit-serial N-bit adder/subtractor built around the existing one-bit full adder `fa`. It processes one bit per clock, LSB first, and stores the carry in a flip-flop between bits. Operands are loaded and the result is returned through a 4-phase req/ack handshake, so a sequential bench or controller can exercise the full-adder datapath over multi-bit words.

---
 rtl/serial_addsub_pkg.sv | 15 +
 rtl/serial_addsub_if.sv | 28 ++
 rtl/serial_addsub_fa.sv | 13 +
 rtl/serial_addsub.sv | 94 +++++++++
 tb/tb_serial_addsub.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    localparam int N_DEFAULT = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/acknowledge bus of the serial adder: operands in, result and status out.
interface serial_addsub_if
    import serial_addsub_pkg::*;
#(
    parameter int N = N_DEFAULT
) ();

    logic         req;
    logic         op;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         ack;
    logic         busy;
    logic [N-1:0] r;
    logic         co;
    logic         ovf;

    modport master (
        output req, op, x, y,
        input  ack, busy, r, co, ovf
    );

    modport slave (
        input  req, op, x, y,
        output ack, busy, r, co, ovf
    );

endinterface

// File: rtl/serial_addsub_fa.sv
// One-bit full adder used as the per-bit datapath of serial_addsub.
module fa (
    output logic co,
    output logic s,
    input  logic ci,
    input  logic x,
    input  logic y
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit add/subtract, LSB first, one bit per clock through a single
// full adder; subtraction is x + ~y + 1 with the +1 preloaded into the carry.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input logic             clk,
    input logic             rst_n,
    serial_addsub_if.slave  bus
);

    localparam int             CW   = $clog2(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_e        r_state;
    logic [N-1:0]  r_xs;
    logic [N-1:0]  r_ys;
    logic [N-1:0]  r_acc;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_r;
    logic          r_co;
    logic          r_ovf;

    logic          w_sum;
    logic          w_fa_co;
    logic [N-1:0]  w_acc_next;

    fa u_fa (
        .co (w_fa_co),
        .s  (w_sum),
        .ci (r_carry),
        .x  (r_xs[0]),
        .y  (r_ys[0])
    );

    assign w_acc_next = {w_sum, r_acc[N-1:1]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_xs    <= '0;
            r_ys    <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_r     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req) begin
                        r_xs    <= bus.x;
                        r_ys    <= (bus.op == OP_SUB) ? ~bus.y : bus.y;
                        r_carry <= bus.op;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_xs    <= r_xs >> 1;
                    r_ys    <= r_ys >> 1;
                    r_carry <= w_fa_co;
                    r_cnt   <= r_cnt + CW'(1);
                    // On the MSB, r_carry is the carry into bit N-1.
                    if (r_cnt == LAST) begin
                        r_r     <= w_acc_next;
                        r_co    <= w_fa_co;
                        r_ovf   <= r_carry ^ w_fa_co;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.req) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ack  = (r_state == DONE);
    assign bus.busy = (r_state == RUN);
    assign bus.r    = r_r;
    assign bus.co   = r_co;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: vector table, handshake corners,
// mid-operation reset and a random sweep against a reference model.
module tb_serial_addsub;
    import serial_addsub_pkg::*;

    localparam int N      = 8;
    localparam int BUDGET = 100;

    typedef struct {
        logic       op;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] r;
        logic       co;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [7:0] r;
        logic       co;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    serial_addsub_if #(.N(N)) bus ();

    serial_addsub #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic op, input logic [7:0] x, input logic [7:0] y);
        exp_t       e;
        logic [8:0] full;
        logic [7:0] yy;
        yy    = op ? ~y : y;
        full  = {1'b0, x} + {1'b0, yy} + {8'd0, op};
        e.r   = full[7:0];
        e.co  = full[8];
        e.ovf = (x[7] == yy[7]) && (e.r[7] != x[7]);
        return e;
    endfunction

    // Called at a negedge: present the operands, raise req, record expectation.
    task automatic start_op(input logic op, input logic [7:0] x, input logic [7:0] y, input exp_t e);
        bus.req = 1'b1;
        bus.op  = op;
        bus.x   = x;
        bus.y   = y;
        sb.push_back(e);
    endtask

    // Called at the negedge after the sampling edge; returns at the first negedge with ack.
    task automatic wait_result(input string tag, input logic pulse, output int lat, output int busy_n);
        exp_t e;
        lat    = 0;
        busy_n = 0;
        @(negedge clk);
        if (pulse) bus.req = 1'b0;
        bus.x = $urandom;
        bus.y = $urandom;
        while (!bus.ack && lat < BUDGET) begin
            busy_n += int'(bus.busy);
            lat++;
            @(negedge clk);
        end
        if (!bus.ack) begin
            check({tag, "_ack_timeout"}, 32'(bus.ack), 32'd1);
        end else if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_r"}, 32'(bus.r), 32'(e.r));
            check({tag, "_co"}, 32'(bus.co), 32'(e.co));
            check({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
            check({tag, "_busy_at_ack"}, 32'(bus.busy), 32'd0);
        end
    endtask

    // Drops req and confirms ack falls one edge later.
    task automatic release_req(input string tag);
        bus.req = 1'b0;
        @(negedge clk);
        check({tag, "_ack_fall"}, 32'(bus.ack), 32'd0);
    endtask

    initial begin
        int   lat;
        int   busy_n;
        exp_t e;
        logic op;
        logic [7:0] x, y;

        vecs[0] = '{OP_ADD, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{OP_SUB, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{OP_ADD, 8'h33, 8'h44, 8'h77, 1'b0, 1'b0};

        rst_n  = 1'b0;
        bus.req = 1'b0;
        bus.op  = OP_ADD;
        bus.x   = '0;
        bus.y   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_ack",  32'(bus.ack),  32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_r",    32'(bus.r),    32'd0);
        check("rst_co",   32'(bus.co),   32'd0);
        check("rst_ovf",  32'(bus.ovf),  32'd0);
        @(negedge clk);

        // Table vectors, req held until ack; latency and busy span checked each time.
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].op, vecs[i].x, vecs[i].y, '{vecs[i].r, vecs[i].co, vecs[i].ovf});
            wait_result($sformatf("vec%0d", i), 1'b0, lat, busy_n);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(N));
            check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'(N));
            release_req($sformatf("vec%0d", i));
        end

        // req pulsed for one cycle: ack must be high for exactly one cycle.
        start_op(OP_ADD, 8'h12, 8'h34, '{8'h46, 1'b0, 1'b0});
        wait_result("pulse", 1'b1, lat, busy_n);
        check("pulse_latency", 32'(lat), 32'(N));
        @(negedge clk);
        check("pulse_ack_one_cycle", 32'(bus.ack), 32'd0);
        check("pulse_idle_busy", 32'(bus.busy), 32'd0);
        check("pulse_r_hold", 32'(bus.r), 32'h46);

        // req held high after ack: ack stays, no second operation begins.
        start_op(OP_SUB, 8'h00, 8'h01, '{8'hFF, 1'b0, 1'b0});
        wait_result("hold", 1'b0, lat, busy_n);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("hold_ack_%0d", i), 32'(bus.ack), 32'd1);
            check($sformatf("hold_busy_%0d", i), 32'(bus.busy), 32'd0);
        end
        // req low exactly one cycle, then a second operation.
        release_req("hold");
        start_op(OP_ADD, 8'hA0, 8'h0B, '{8'hAB, 1'b0, 1'b0});
        wait_result("relaunch", 1'b0, lat, busy_n);
        check("relaunch_latency", 32'(lat), 32'(N));
        release_req("relaunch");

        // Reset at RUN cycle 4 of 0x33+0x44 aborts with nothing visible.
        bus.req = 1'b1;
        bus.op  = OP_ADD;
        bus.x   = 8'h33;
        bus.y   = 8'h44;
        repeat (4) @(negedge clk);
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 1'b0;
        check("abort_ack",  32'(bus.ack),  32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_r",    32'(bus.r),    32'd0);
        repeat (N + 2) @(negedge clk);
        check("abort_no_late_ack", 32'(bus.ack), 32'd0);
        start_op(OP_ADD, 8'h33, 8'h44, '{8'h77, 1'b0, 1'b0});
        wait_result("after_abort", 1'b0, lat, busy_n);
        release_req("after_abort");

        // Random sweep against the reference model.
        for (int i = 0; i < 1000; i++) begin
            op = 1'($urandom_range(0, 1));
            x  = 8'($urandom);
            y  = 8'($urandom);
            e  = model(op, x, y);
            start_op(op, x, y, e);
            wait_result($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), lat, busy_n);
            if (bus.req) begin
                release_req($sformatf("rnd%0d", i));
            end else begin
                @(negedge clk);
                check($sformatf("rnd%0d_ack_fall", i), 32'(bus.ack), 32'd0);
            end
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
